// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between a display front end and the 4-digit segment scanner.
// The master side supplies digit data and control; the slave side is the scanner.
interface seg_scan_ctrl_if;
    logic       enable;
    logic [7:0] digit0;
    logic [7:0] digit1;
    logic [7:0] digit2;
    logic [7:0] digit3;
    logic [3:0] blink_en;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    modport master (
        output enable, digit0, digit1, digit2, digit3, blink_en,
        input  seg, an, frame_tick
    );

    modport slave (
        input  enable, digit0, digit1, digit2, digit3, blink_en,
        output seg, an, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with per-slot ghosting guard,
// tear-free per-slot digit capture and per-digit blinking.
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 100,
    parameter int BLINK_FRAMES = 250
) (
    input  logic           clk_100MHz,
    input  logic           reset_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  GUARD_LAST = SLOT_W'(GUARD - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t             r_state;
    logic [SLOT_W-1:0]  r_slot_cnt;
    logic [1:0]         r_idx;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_blink_phase;
    logic [7:0]         r_slot_reg;
    logic               r_slot_blink;
    logic [7:0]         r_seg;
    logic [3:0]         r_an;
    logic               r_frame_tick;

    state_t             w_state_nxt;
    logic [SLOT_W-1:0]  w_slot_nxt;
    logic [1:0]         w_idx_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic               w_phase_nxt;
    logic               w_frame_end;
    logic               w_capture;
    logic [7:0]         w_digit_sel;
    logic               w_drive_on;
    logic [7:0]         w_seg_nxt;
    logic [3:0]         w_an_nxt;

    // Next-state and counter update; dropping enable abandons the slot and clears everything.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot_cnt;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame_cnt;
        w_phase_nxt = r_blink_phase;
        w_frame_end = 1'b0;
        w_capture   = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_slot_nxt  = '0;
            w_idx_nxt   = 2'd0;
            w_frame_nxt = '0;
            w_phase_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_GUARD;
                    w_slot_nxt  = '0;
                    w_idx_nxt   = 2'd0;
                end
                ST_GUARD: begin
                    w_capture  = (r_slot_cnt == '0);
                    w_slot_nxt = r_slot_cnt + 1'b1;
                    if (r_slot_cnt == GUARD_LAST) begin
                        w_state_nxt = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_slot_cnt == SLOT_LAST) begin
                        w_state_nxt = ST_GUARD;
                        w_slot_nxt  = '0;
                        w_idx_nxt   = r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            w_frame_end = 1'b1;
                            if (r_frame_cnt == FRAME_LAST) begin
                                w_frame_nxt = '0;
                                w_phase_nxt = ~r_blink_phase;
                            end else begin
                                w_frame_nxt = r_frame_cnt + 1'b1;
                            end
                        end
                    end else begin
                        w_slot_nxt = r_slot_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_slot_nxt  = '0;
                    w_idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Digit select for the slot about to be captured.
    always_comb begin
        w_digit_sel = bus.digit0;
        unique case (r_idx)
            2'd0: w_digit_sel = bus.digit0;
            2'd1: w_digit_sel = bus.digit1;
            2'd2: w_digit_sel = bus.digit2;
            2'd3: w_digit_sel = bus.digit3;
            default: w_digit_sel = bus.digit0;
        endcase
    end

    // Output decode; enable is included so the bus darkens on the very next edge after it drops.
    always_comb begin
        w_drive_on = bus.enable && (r_state == ST_DRIVE) && !(r_blink_phase && r_slot_blink);
        w_seg_nxt  = 8'hFF;
        w_an_nxt   = 4'hF;
        if (w_drive_on) begin
            w_seg_nxt = r_slot_reg;
            w_an_nxt  = ~(4'b0001 << r_idx);
        end
    end

    // FSM state and scan counters.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_slot_cnt    <= '0;
            r_idx         <= 2'd0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot_cnt    <= w_slot_nxt;
            r_idx         <= w_idx_nxt;
            r_frame_cnt   <= w_frame_nxt;
            r_blink_phase <= w_phase_nxt;
        end
    end

    // Slot register: digit data and its blink flag are frozen at slot start.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_reg   <= 8'hFF;
            r_slot_blink <= 1'b0;
        end else if (w_capture) begin
            r_slot_reg   <= w_digit_sel;
            r_slot_blink <= bus.blink_en[r_idx];
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_seg        <= 8'hFF;
            r_an         <= 4'hF;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
            r_frame_tick <= w_frame_end;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a timeline-based reference model.
module tb_seg_scan_ctrl;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int BF = 2;
    localparam int FRAME_LEN = SD * 4;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [7:0] dig [4];
    logic [3:0] blink_en;

    int n_tests;
    int n_fail;

    // reference model: position on the scan timeline of the state after the last edge
    bit         m_active;
    int         m_t;
    logic [7:0] m_cap_seg;
    logic       m_cap_blink;
    int         ft_seen;

    seg_scan_ctrl_if bus ();

    assign bus.enable   = enable;
    assign bus.digit0   = dig[0];
    assign bus.digit1   = dig[1];
    assign bus.digit2   = dig[2];
    assign bus.digit3   = dig[3];
    assign bus.blink_en = blink_en;

    seg_scan_ctrl #(
        .SCAN_DIV     (SD),
        .GUARD        (GD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit an_ok(input logic [3:0] a);
        int lows;
        lows = 0;
        for (int i = 0; i < 4; i++) if (a[i] === 1'b0) lows++;
        return (lows <= 1) && !$isunknown(a);
    endfunction

    // One clock edge: predict outputs from the pre-edge inputs, then compare 1 time unit later.
    task automatic tick();
        logic [7:0] e_seg;
        logic [3:0] e_an;
        logic       e_ft;
        logic [3:0] one;
        int s, id, fr;
        @(posedge clk);
        e_seg = 8'hFF;
        e_an  = 4'hF;
        e_ft  = 1'b0;
        if (!reset_n || !enable) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t      = 0;
        end else begin
            s  = m_t % SD;
            id = (m_t / SD) % 4;
            fr = m_t / FRAME_LEN;
            if (s == 0) begin
                m_cap_seg   = dig[id];
                m_cap_blink = blink_en[id];
            end
            if (s >= GD && !(((fr / BF) % 2 == 1) && m_cap_blink)) begin
                one   = 4'b0001 << id;
                e_seg = m_cap_seg;
                e_an  = ~one;
            end
            e_ft = (s == SD - 1) && (id == 3);
            m_t++;
        end
        #1;
        check_val("seg", {24'd0, bus.seg}, {24'd0, e_seg});
        check_val("an", {28'd0, bus.an}, {28'd0, e_an});
        check_val("frame_tick", {31'd0, bus.frame_tick}, {31'd0, e_ft});
        check_val("an_onehot", {31'd0, an_ok(bus.an)}, 32'd1);
        if (bus.frame_tick === 1'b1) ft_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next edge will evaluate timeline position pos within a frame.
    task automatic run_to(input int pos);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            if (m_active && (m_t % FRAME_LEN) == pos) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_val("sync_timeout", {31'd0, found}, 32'd1);
    endtask

    // Asynchronous reset pulse placed between edges and held over one edge.
    task automatic reset_pulse();
        #3;
        reset_n = 1'b0;
        #1;
        check_val("rst_async_seg", {24'd0, bus.seg}, 32'h0000_00FF);
        check_val("rst_async_an", {28'd0, bus.an}, 32'h0000_000F);
        check_val("rst_async_ft", {31'd0, bus.frame_tick}, 32'd0);
        check_val("rst_an_onehot", {31'd0, an_ok(bus.an)}, 32'd1);
        m_active = 1'b0;
        m_t      = 0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        m_active = 1'b0;
        m_t      = 0;
        m_cap_seg   = 8'hFF;
        m_cap_blink = 1'b0;
        ft_seen  = 0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        blink_en = 4'b0000;
        dig[0] = 8'hE3;
        dig[1] = 8'hC5;
        dig[2] = 8'h91;
        dig[3] = 8'h61;

        // reset state
        ticks(3);
        check_val("reset_seg", {24'd0, bus.seg}, 32'h0000_00FF);
        check_val("reset_an", {28'd0, bus.an}, 32'h0000_000F);
        check_val("reset_ft", {31'd0, bus.frame_tick}, 32'd0);
        reset_n = 1'b1;
        ticks(2);

        // basic scan, two frames exactly two frame pulses
        enable = 1'b1;
        tick();
        ft_seen = 0;
        ticks(2 * FRAME_LEN);
        check_val("ft_per_2frames", ft_seen, 32'd2);

        // tear-free capture: change digit1 at cycle 4 of slot 1
        run_to(SD + 4);
        dig[1] = 8'h00;
        ticks(FRAME_LEN + SD);

        // blink digit 2 over six frames
        dig[1]   = 8'hC5;
        enable   = 1'b0;
        tick();
        blink_en = 4'b0100;
        enable   = 1'b1;
        ticks(6 * FRAME_LEN + 1);
        blink_en = 4'b0000;

        // enable drop at scan cycle 13, then restart
        enable = 1'b0;
        tick();
        enable = 1'b1;
        ticks(13);
        enable = 1'b0;
        ticks(4);
        enable = 1'b1;
        ticks(FRAME_LEN + 4);

        // reset during DRIVE of digit 3, just before its frame end
        run_to(3 * SD + 6);
        ft_seen = 0;
        reset_pulse();
        ticks(FRAME_LEN - 2);
        check_val("no_ft_after_rst", ft_seen, 32'd0);
        ticks(8);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) dig[$urandom_range(0, 3)] = 8'($urandom);
            if ($urandom_range(0, 99) == 0) blink_en = 4'($urandom);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
            if ($urandom_range(0, 599) == 0) reset_pulse();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles per digit slot (legal range is GUARD+2 or more).
REQ-002 The block SHALL have parameter GUARD, default 100, meaning blanking cycles at the start of each slot (ghosting guard).
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 250, meaning full 4-digit frames per blink half-period.
REQ-004 The block SHALL have port clk_100MHz, input, width 1: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, width 1: the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port enable, input, width 1: 1 means scan, 0 means display dark.
REQ-007 The block SHALL have ports digit0, digit1, digit2 and digit3, each input, width 8: active-low segment patterns, passed through opaque.
REQ-008 The block SHALL have port blink_en, input, width 4: bit i set means digit i blinks.
REQ-009 The block SHALL have port seg, output, width 8: the registered active-low segment bus shared by all digits.
REQ-010 The block SHALL have port an, output, width 4: registered active-low anode selects, with at most one bit low.
REQ-011 The block SHALL have port frame_tick, output, width 1: a one-cycle pulse at the end of each full frame.

Function
REQ-012 The block SHALL keep slot_cnt (0..SCAN_DIV-1), idx (0..3), frame_cnt (0..BLINK_FRAMES-1) and blink_phase (1 bit).
REQ-013 The FSM SHALL use states IDLE, GUARD and DRIVE.
REQ-014 The IDLE to GUARD transition SHALL occur when enable=1; slot_cnt=0 and idx=0 on entry.
REQ-015 The GUARD to DRIVE transition SHALL occur when slot_cnt reaches GUARD-1.
REQ-016 The DRIVE to GUARD transition SHALL occur when slot_cnt=SCAN_DIV-1; slot_cnt then returns to 0 and idx increments, wrapping from 3 to 0.
REQ-017 Any state SHALL go to IDLE on the cycle after enable=0.
REQ-018 In IDLE, all counters SHALL be cleared, blink_phase SHALL be cleared, an=4'b1111 and seg=8'hFF.
REQ-019 On the cycle where slot_cnt=0, the block SHALL capture digit[idx] into an internal slot register; later changes to digit inputs SHALL NOT affect the current slot (no tearing).
REQ-020 seg and an SHALL be registered, with one cycle of latency from the FSM state and counters.
REQ-021 In GUARD, the block SHALL output an=4'b1111 and seg=8'hFF.
REQ-022 In DRIVE, the block SHALL output seg=the slot register, and an SHALL have bit idx low and all other bits high.
REQ-023 If blink_phase=1 and blink_en[idx]=1, then in DRIVE the block SHALL output an=4'b1111 and seg=8'hFF; the slot timing SHALL be unchanged.
REQ-024 blink_en SHALL be sampled at slot start together with the digit data.
REQ-025 frame_tick SHALL be 1 for exactly one cycle, registered, following the cycle where idx=3 and slot_cnt=SCAN_DIV-1.
REQ-026 At that same frame end, frame_cnt SHALL increment; when frame_cnt=BLINK_FRAMES-1 it SHALL wrap to 0 and blink_phase SHALL toggle.
REQ-027 At most one bit of an SHALL be low in any cycle, including across the enable edge and the reset edge.
REQ-028 A reset or enable drop mid-slot SHALL abandon the slot; a restart SHALL always begin at digit 0 in GUARD with blink_phase=0.

Reset
REQ-029 When reset_n=0, the block SHALL asynchronously force IDLE, clear all counters, clear blink_phase and the slot register, and output an=4'b1111, seg=8'hFF and frame_tick=0.
REQ-030 On reset_n release with enable=1, the first cycle SHALL be GUARD for digit 0.

Verification (SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2)
REQ-031 A bench SHALL cover basic scan: digit0..3=8'hE3, 8'hC5, 8'h91, 8'h61, enable=1 -> per 8-cycle slot, 2 cycles an=1111/seg=FF then 6 cycles an=1110/seg=E3, an=1101/seg=C5, an=1011/seg=91, an=0111/seg=61, repeating; frame_tick once every 32 cycles.
REQ-032 A bench SHALL cover capture: digit1 changes from 8'hC5 to 8'h00 at slot cycle 4 -> seg stays C5 for the rest of slot 1 and shows 00 in the next frame's slot 1.
REQ-033 A bench SHALL cover blink: blink_en=4'b0100 -> digit 2 is visible in frames 0-1, dark (an=1111) in frames 2-3, and visible again in frames 4-5; other digits are never dark in DRIVE.
REQ-034 A bench SHALL cover an enable drop: enable=0 at cycle 13 of the scan -> from the next output cycle an=1111/seg=FF; on re-enable, scan restarts at digit 0 with 2 guard cycles.
REQ-035 A bench SHALL cover mid-slot reset: reset_n pulsed low during DRIVE of digit 3 -> outputs go dark immediately (asynchronously), no frame_tick is produced, and after release the scan restarts at digit 0.
REQ-036 A bench SHALL check the one-hot-low invariant: across all scenarios, an never has two bits low, checked every cycle.
